// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - UART receive deserializer
//
// Synchronizes the raw serial line, finds start bits using OVERSAMPLE-times
// oversampling, shifts in 5..8 data bits LSB first, checks optional parity
// and one or two stop bits, then pushes the byte into the RX queue.
//
// Ports:
//   clk                  system clock
//   reset                synchronous, active-high reset
//   rx                   asynchronous serial input, idle high
//   clock_divisor        sample tick every clock_divisor+1 clocks
//   parity_type          00/11 none, 01 odd, 10 even
//   data_bits_count      00..11 -> 5..8 data bits
//   double_stop_bits     1 = two stop bits
//   rx_queue_full        RX queue cannot accept a push
//   rx_data              last received byte, zero-extended
//   rx_push              one-cycle queue write strobe
//   overrun              one-cycle pulse: frame dropped, queue full
//   rx_sync              synchronized rx line
//   parity_error_if_en   one-cycle strobe at the parity sample
//   rx_parity_out        parity mismatch flag, valid with the strobe above
//   stop_bit_error_if_en one-cycle strobe at each stop-bit sample
//   busy                 receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [4:0] clock_divisor,
    input  logic [1:0] parity_type,
    input  logic [1:0] data_bits_count,
    input  logic       double_stop_bits,
    input  logic       rx_queue_full,
    output logic [7:0] rx_data,
    output logic       rx_push,
    output logic       overrun,
    output logic       rx_sync,
    output logic       parity_error_if_en,
    output logic       rx_parity_out,
    output logic       stop_bit_error_if_en,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_DONE
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizer, reset to the idle (high) line level
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) sync_q[gi] <= 1'b1;
                    else       sync_q[gi] <= rx;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) sync_q[gi] <= 1'b1;
                    else       sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign rx_sync = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t          state_q;
    logic            rx_prev_q;
    logic [4:0]      div_q;
    logic [CW-1:0]   tick_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic [1:0]      parity_cfg_q;
    logic [1:0]      data_bits_cfg_q;
    logic            dbl_stop_cfg_q;

    logic [7:0]      rx_data_q;
    logic            rx_push_q;
    logic            overrun_q;
    logic            parity_error_if_en_q;
    logic            rx_parity_out_q;
    logic            stop_bit_error_if_en_q;
    logic            busy_q;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic            tick;
    logic            start_edge;
    logic            half_hit;
    logic            full_hit;
    logic            last_bit;
    logic            parity_en;
    logic            parity_err_d;
    logic [7:0]      shift_d;
    logic [7:0]      justified_d;

    always_comb begin
        tick        = (div_q == clock_divisor);
        start_edge  = (state_q == S_IDLE) && rx_prev_q && !rx_sync;
        half_hit    = tick && (tick_cnt_q == HALF_M1);
        full_hit    = tick && (tick_cnt_q == FULL_M1);
        last_bit    = (bit_cnt_q == ({1'b0, data_bits_cfg_q} + 3'd4));
        parity_en   = (parity_cfg_q == 2'b01) || (parity_cfg_q == 2'b10);
        shift_d     = {rx_sync, shift_q[7:1]};
        // Bits arrive at the top of the register; a short word has to be
        // moved down by 8-N so the unused upper bits read as zero.
        justified_d = shift_d >> (2'd3 - data_bits_cfg_q);
        // shift_q is already right-justified with zeros above the data, so
        // the reduction XOR covers exactly data bits plus the parity bit.
        parity_err_d = (^shift_q) ^ rx_sync;
        if (parity_cfg_q == 2'b01) begin
            parity_err_d = ~parity_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Receiver FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                <= S_IDLE;
            rx_prev_q              <= 1'b1;
            div_q                  <= '0;
            tick_cnt_q             <= '0;
            bit_cnt_q              <= '0;
            shift_q                <= '0;
            parity_cfg_q           <= '0;
            data_bits_cfg_q        <= '0;
            dbl_stop_cfg_q         <= 1'b0;
            rx_data_q              <= '0;
            rx_push_q              <= 1'b0;
            overrun_q              <= 1'b0;
            parity_error_if_en_q   <= 1'b0;
            rx_parity_out_q        <= 1'b0;
            stop_bit_error_if_en_q <= 1'b0;
            busy_q                 <= 1'b0;
        end else begin
            rx_push_q              <= 1'b0;
            overrun_q              <= 1'b0;
            parity_error_if_en_q   <= 1'b0;
            rx_parity_out_q        <= 1'b0;
            stop_bit_error_if_en_q <= 1'b0;

            rx_prev_q <= rx_sync;
            div_q     <= tick ? 5'd0 : div_q + 5'd1;
            if (tick && state_q != S_IDLE) begin
                tick_cnt_q <= tick_cnt_q + CW'(1);
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        // Re-phase the divider so ticks count from the edge.
                        state_q         <= S_START;
                        div_q           <= '0;
                        tick_cnt_q      <= '0;
                        bit_cnt_q       <= '0;
                        shift_q         <= '0;
                        parity_cfg_q    <= parity_type;
                        data_bits_cfg_q <= data_bits_count;
                        dbl_stop_cfg_q  <= double_stop_bits;
                        busy_q          <= 1'b1;
                    end
                end

                S_START: begin
                    if (half_hit) begin
                        tick_cnt_q <= '0;
                        if (rx_sync) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (full_hit) begin
                        if (last_bit) begin
                            shift_q   <= justified_d;
                            bit_cnt_q <= '0;
                            state_q   <= parity_en ? S_PARITY : S_STOP1;
                        end else begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (full_hit) begin
                        parity_error_if_en_q <= 1'b1;
                        rx_parity_out_q      <= parity_err_d;
                        state_q              <= S_STOP1;
                    end
                end

                S_STOP1: begin
                    if (full_hit) begin
                        stop_bit_error_if_en_q <= 1'b1;
                        state_q <= dbl_stop_cfg_q ? S_STOP2 : S_DONE;
                    end
                end

                S_STOP2: begin
                    if (full_hit) begin
                        stop_bit_error_if_en_q <= 1'b1;
                        state_q                <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Stop errors do not suppress the push; they are only
                    // reported through the stop strobe.
                    if (rx_queue_full) begin
                        overrun_q <= 1'b1;
                    end else begin
                        rx_push_q <= 1'b1;
                        rx_data_q <= shift_q;
                    end
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data              = rx_data_q;
    assign rx_push              = rx_push_q;
    assign overrun              = overrun_q;
    assign parity_error_if_en   = parity_error_if_en_q;
    assign rx_parity_out        = rx_parity_out_q;
    assign stop_bit_error_if_en = stop_bit_error_if_en_q;
    assign busy                 = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx - self-checking bench for uart_rx
//
// A negedge monitor records every strobe the receiver emits and checks each
// rx_push against a queue of expected bytes filled by the scenario tasks.
// Each scenario task then checks the recorded strobe counts and values.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [4:0] clock_divisor;
    logic [1:0] parity_type;
    logic [1:0] data_bits_count;
    logic       double_stop_bits;
    logic       rx_queue_full;
    logic [7:0] rx_data;
    logic       rx_push;
    logic       overrun;
    logic       rx_sync;
    logic       parity_error_if_en;
    logic       rx_parity_out;
    logic       stop_bit_error_if_en;
    logic       busy;

    uart_rx #(
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .rx                   (rx),
        .clock_divisor        (clock_divisor),
        .parity_type          (parity_type),
        .data_bits_count      (data_bits_count),
        .double_stop_bits     (double_stop_bits),
        .rx_queue_full        (rx_queue_full),
        .rx_data              (rx_data),
        .rx_push              (rx_push),
        .overrun              (overrun),
        .rx_sync              (rx_sync),
        .parity_error_if_en   (parity_error_if_en),
        .rx_parity_out        (rx_parity_out),
        .stop_bit_error_if_en (stop_bit_error_if_en),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard and monitor records
    logic [7:0] exp_q[$];
    logic       stop_vals[$];
    int         push_n;
    int         ovr_n;
    int         par_n;
    logic       last_par;
    time        push_t;
    time        stop_t;
    logic       busy_seen;

    always @(negedge clk) begin
        int ns;
        logic [7:0] e;
        ns = int'(rx_push) + int'(overrun) + int'(parity_error_if_en)
           + int'(stop_bit_error_if_en);
        if (ns != 0) begin
            total++;
            if (ns > 1) begin
                bad++;
                $display("FAIL strobe_overlap: %0d strobes in one cycle, required at most 1", ns);
            end
        end
        if (busy) busy_seen = 1'b1;
        if (rx_push) begin
            push_n++;
            push_t = $time;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_push: rx_data=%02h with no frame expected", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    bad++;
                    $display("FAIL push_data: rx_data=%02h required %02h", rx_data, e);
                end
            end
        end
        if (overrun) ovr_n++;
        if (parity_error_if_en) begin
            par_n++;
            last_par = rx_parity_out;
        end
        if (stop_bit_error_if_en) begin
            stop_vals.push_back(rx_sync);
            stop_t = $time;
        end
    end

    task automatic clear_obs();
        push_n = 0;
        ovr_n = 0;
        par_n = 0;
        last_par = 1'bx;
        push_t = 0;
        stop_t = 0;
        busy_seen = 1'b0;
        stop_vals.delete();
    endtask

    task automatic set_cfg(input logic [1:0] dbc, input logic [1:0] par,
                           input logic dbl, input logic [4:0] div);
        data_bits_count  = dbc;
        parity_type      = par;
        double_stop_bits = dbl;
        clock_divisor    = div;
    endtask

    // Drives one frame on rx; t0 is the time the start bit was driven.
    task automatic send_frame(input logic [7:0] data, input int nbits,
                              input bit has_par, input logic par_bit,
                              input logic stop1, input logic stop2,
                              input bit two_stop, input int div,
                              output time t0);
        int bc;
        bc = 16 * (div + 1);
        @(negedge clk);
        t0 = $time;
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = data[i];
            repeat (bc) @(negedge clk);
        end
        if (has_par) begin
            rx = par_bit;
            repeat (bc) @(negedge clk);
        end
        rx = stop1;
        repeat (bc) @(negedge clk);
        if (two_stop) begin
            rx = stop2;
            repeat (bc) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b0;
        repeat (4) @(negedge clk);
        total += 7;
        if (rx_sync !== 1'b1) begin bad++; $display("FAIL reset_rx_sync: got %b required 1", rx_sync); end
        if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %02h required 00", rx_data); end
        if (rx_push !== 1'b0) begin bad++; $display("FAIL reset_rx_push: got %b required 0", rx_push); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b required 0", overrun); end
        if (parity_error_if_en !== 1'b0 || rx_parity_out !== 1'b0) begin
            bad++; $display("FAIL reset_parity: got %b/%b required 0/0", parity_error_if_en, rx_parity_out);
        end
        if (stop_bit_error_if_en !== 1'b0) begin bad++; $display("FAIL reset_stop: got %b required 0", stop_bit_error_if_en); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic test_8n1();
        time t0;
        bit  ok;
        clear_obs();
        set_cfg(2'b11, 2'b00, 1'b0, 5'd0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 8, 0, 1'b0, 1'b1, 1'b1, 0, 0, t0);
        wait_idle(ok);
        total += 7;
        if (!ok) begin bad++; $display("FAIL 8n1_idle: busy stuck high"); end
        if (push_n !== 1) begin bad++; $display("FAIL 8n1_push_count: got %0d required 1", push_n); end
        if (par_n !== 0) begin bad++; $display("FAIL 8n1_parity_strobes: got %0d required 0", par_n); end
        if (stop_vals.size() !== 1 || stop_vals[0] !== 1'b1) begin
            bad++; $display("FAIL 8n1_stop: %0d strobes, first rx_sync=%b, required 1 strobe with 1", stop_vals.size(), stop_vals.size() > 0 ? stop_vals[0] : 1'bx);
        end
        // start edge seen 3 clocks after rx falls; stop sample 8+9*16 ticks later
        if (stop_t - t0 !== 64'd1550) begin bad++; $display("FAIL 8n1_stop_time: got %0t required 1550 after start", stop_t - t0); end
        if (push_t - stop_t !== 64'd10) begin bad++; $display("FAIL 8n1_push_latency: got %0t required 10", push_t - stop_t); end
        if (rx_data !== 8'hA5) begin bad++; $display("FAIL 8n1_hold: rx_data=%02h required a5", rx_data); end
        $display("test_8n1: frame a5 pushes=%0d stops=%0d", push_n, stop_vals.size());
    endtask

    task automatic test_parity();
        time t0;
        bit  ok;
        // 7E1: 0x55 has four ones, so a parity bit of 1 is a mismatch.
        clear_obs();
        set_cfg(2'b10, 2'b10, 1'b0, 5'd3);
        exp_q.push_back(8'h55);
        send_frame(8'hD5, 7, 1, 1'b1, 1'b1, 1'b1, 0, 3, t0);
        wait_idle(ok);
        total += 5;
        if (!ok) begin bad++; $display("FAIL 7e1_idle: busy stuck high"); end
        if (par_n !== 1) begin bad++; $display("FAIL 7e1_parity_count: got %0d required 1", par_n); end
        if (last_par !== 1'b1) begin bad++; $display("FAIL 7e1_parity_err: got %b required 1", last_par); end
        if (rx_data !== 8'h55) begin bad++; $display("FAIL 7e1_data: rx_data=%02h required 55", rx_data); end
        if (push_n !== 1) begin bad++; $display("FAIL 7e1_push_count: got %0d required 1", push_n); end
        $display("test_parity: 7e1 frame 55 parity_out=%b", last_par);

        // 6O1: 0x2A has three ones, parity bit 0 keeps the total odd.
        clear_obs();
        set_cfg(2'b01, 2'b01, 1'b0, 5'd3);
        exp_q.push_back(8'h2A);
        send_frame(8'h2A, 6, 1, 1'b0, 1'b1, 1'b1, 0, 3, t0);
        wait_idle(ok);
        total += 3;
        if (par_n !== 1) begin bad++; $display("FAIL 6o1_parity_count: got %0d required 1", par_n); end
        if (last_par !== 1'b0) begin bad++; $display("FAIL 6o1_parity_err: got %b required 0", last_par); end
        if (push_n !== 1) begin bad++; $display("FAIL 6o1_push_count: got %0d required 1", push_n); end
        $display("test_parity: 6o1 frame 2a parity_out=%b", last_par);
    endtask

    task automatic test_false_start();
        clear_obs();
        set_cfg(2'b11, 2'b00, 1'b0, 5'd0);
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        total += 4;
        if (busy_seen !== 1'b1) begin bad++; $display("FAIL false_start_busy_seen: got %b required 1", busy_seen); end
        if (busy !== 1'b0) begin bad++; $display("FAIL false_start_busy: got %b required 0", busy); end
        if (push_n !== 0 || ovr_n !== 0) begin bad++; $display("FAIL false_start_push: push=%0d overrun=%0d required 0/0", push_n, ovr_n); end
        if (par_n !== 0 || stop_vals.size() !== 0) begin
            bad++; $display("FAIL false_start_strobes: parity=%0d stop=%0d required 0/0", par_n, stop_vals.size());
        end
        $display("test_false_start: pushes=%0d", push_n);
    endtask

    task automatic test_stop_error();
        time t0;
        bit  ok;
        clear_obs();
        set_cfg(2'b00, 2'b00, 1'b1, 5'd0);
        exp_q.push_back(8'h1F);
        send_frame(8'h1F, 5, 0, 1'b0, 1'b1, 1'b0, 1, 0, t0);
        wait_idle(ok);
        total += 4;
        if (!ok) begin bad++; $display("FAIL stop_err_idle: busy stuck high"); end
        if (stop_vals.size() !== 2) begin
            bad++; $display("FAIL stop_err_count: got %0d required 2", stop_vals.size());
        end else if (stop_vals[0] !== 1'b1 || stop_vals[1] !== 1'b0) begin
            bad++; $display("FAIL stop_err_values: got %b%b required 10", stop_vals[0], stop_vals[1]);
        end
        if (push_n !== 1) begin bad++; $display("FAIL stop_err_push: got %0d required 1", push_n); end
        if (rx_data !== 8'h1F) begin bad++; $display("FAIL stop_err_data: rx_data=%02h required 1f", rx_data); end
        $display("test_stop_error: frame 1f pushes=%0d", push_n);
    endtask

    task automatic test_queue_full();
        time t0;
        bit  ok;
        clear_obs();
        set_cfg(2'b11, 2'b00, 1'b0, 5'd0);
        rx_queue_full = 1'b1;
        send_frame(8'h3C, 8, 0, 1'b0, 1'b1, 1'b1, 0, 0, t0);
        wait_idle(ok);
        rx_queue_full = 1'b0;
        total += 3;
        if (ovr_n !== 1) begin bad++; $display("FAIL full_overrun: got %0d required 1", ovr_n); end
        if (push_n !== 0) begin bad++; $display("FAIL full_push: got %0d required 0", push_n); end
        if (rx_data !== 8'h1F) begin bad++; $display("FAIL full_hold: rx_data=%02h required 1f", rx_data); end
        $display("test_queue_full: overruns=%0d", ovr_n);
    endtask

    task automatic test_reset_mid_frame();
        time t0;
        bit  ok;
        logic [7:0] d;
        clear_obs();
        set_cfg(2'b11, 2'b00, 1'b0, 5'd0);
        d = 8'hAA;
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            repeat (16) @(negedge clk);
        end
        rx = d[3];
        repeat (8) @(negedge clk);
        total += 1;
        if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy_before: got %b required 1", busy); end
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        total += 3;
        if (busy !== 1'b0 || rx_push !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL midreset_ctrl: busy=%b push=%b overrun=%b required 0/0/0", busy, rx_push, overrun);
        end
        if (parity_error_if_en !== 1'b0 || rx_parity_out !== 1'b0 || stop_bit_error_if_en !== 1'b0) begin
            bad++; $display("FAIL midreset_strobes: par=%b parout=%b stop=%b required 0/0/0",
                            parity_error_if_en, rx_parity_out, stop_bit_error_if_en);
        end
        if (rx_data !== 8'h00) begin bad++; $display("FAIL midreset_data: rx_data=%02h required 00", rx_data); end
        reset = 1'b0;
        repeat (200) @(negedge clk);
        total += 1;
        if (push_n !== 0) begin bad++; $display("FAIL midreset_no_push: got %0d required 0", push_n); end

        exp_q.push_back(8'h81);
        send_frame(8'h81, 8, 0, 1'b0, 1'b1, 1'b1, 0, 0, t0);
        wait_idle(ok);
        total += 2;
        if (push_n !== 1) begin bad++; $display("FAIL midreset_next_push: got %0d required 1", push_n); end
        if (rx_data !== 8'h81) begin bad++; $display("FAIL midreset_next_data: rx_data=%02h required 81", rx_data); end
        $display("test_reset_mid_frame: next frame %02h", rx_data);
    endtask

    task automatic test_back_to_back();
        time t0;
        bit  ok;
        clear_obs();
        set_cfg(2'b11, 2'b00, 1'b0, 5'd0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        // Config changes during the first frame must not affect it.
        fork
            send_frame(8'h00, 8, 0, 1'b0, 1'b1, 1'b1, 0, 0, t0);
            begin
                repeat (40) @(negedge clk);
                set_cfg(2'b00, 2'b10, 1'b1, 5'd0);
            end
        join
        set_cfg(2'b11, 2'b00, 1'b0, 5'd0);
        send_frame(8'hFF, 8, 0, 1'b0, 1'b1, 1'b1, 0, 0, t0);
        wait_idle(ok);
        total += 4;
        if (push_n !== 2) begin bad++; $display("FAIL b2b_push_count: got %0d required 2", push_n); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_pending: %0d frames not received, required 0", exp_q.size()); end
        if (par_n !== 0) begin bad++; $display("FAIL b2b_parity: got %0d strobes required 0", par_n); end
        if (stop_vals.size() !== 2) begin bad++; $display("FAIL b2b_stops: got %0d strobes required 2", stop_vals.size()); end
        $display("test_back_to_back: pushes=%0d", push_n);
    endtask

    initial begin
        reset            = 1'b1;
        rx               = 1'b1;
        clock_divisor    = 5'd0;
        parity_type      = 2'b00;
        data_bits_count  = 2'b11;
        double_stop_bits = 1'b0;
        rx_queue_full    = 1'b0;
        clear_obs();
        test_reset();
        test_8n1();
        test_parity();
        test_false_start();
        test_stop_error();
        test_queue_full();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
